// File: rtl/ci_multi_counter_pkg.sv
// Shared types and constants for the multi-channel CI one/zero counter.
package ci_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  localparam int CNT_W_DEF = 16;

  // One extra bit so a frame longer than COLS*ROWS is still distinguishable.
  function automatic int pix_cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ci_multi_counter_if.sv
// Sample/result bus between the CI feature blocks, the counter and the histogram assembler.
interface ci_multi_counter_if import ci_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = CNT_W_DEF
);

  logic                      valid_i;
  logic [NUM_CH-1:0]         ci_i;
  logic                      frame_done_i;
  logic                      busy_o;
  logic                      done_o;
  logic [NUM_CH*CNT_W-1:0]   ones_o;
  logic [NUM_CH*CNT_W-1:0]   zeros_o;
  logic                      count_err_o;
  logic [NUM_CH-1:0]         ovf_o;

  modport master (
    output valid_i, ci_i, frame_done_i,
    input  busy_o, done_o, ones_o, zeros_o, count_err_o, ovf_o
  );

  modport slave (
    input  valid_i, ci_i, frame_done_i,
    output busy_o, done_o, ones_o, zeros_o, count_err_o, ovf_o
  );

endinterface

// File: rtl/ci_multi_counter_ch_counter.sv
// One channel's one/zero counter pair; CI_CNT_SAT_EN selects saturate (defined) or wrap (undefined).
// Next-state values are exported so the top can latch the final counts on the frame-end edge.
module ci_ch_counter import ci_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             bit_i,
  output logic [CNT_W-1:0] ones_d_o,
  output logic [CNT_W-1:0] zeros_d_o,
  output logic             ovf_d_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] ones_q, ones_d, zeros_q, zeros_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] ones_base, zeros_base;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef CI_CNT_SAT_EN
    return (v == CNT_MAX) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  always_comb begin
    ones_base  = clear_i ? '0 : ones_q;
    zeros_base = clear_i ? '0 : zeros_q;
    ones_d     = ones_base;
    zeros_d    = zeros_base;
    ovf_d      = clear_i ? 1'b0 : ovf_q;
    if (inc_i) begin
      if (bit_i) begin
        ones_d = bump(ones_base);
        if (ones_base == CNT_MAX) ovf_d = 1'b1;
      end else begin
        zeros_d = bump(zeros_base);
        if (zeros_base == CNT_MAX) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_q  <= '0;
      zeros_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      zeros_q <= zeros_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ones_d_o  = ones_d;
  assign zeros_d_o = zeros_d;
  assign ovf_d_o   = ovf_d;

endmodule

// File: rtl/ci_multi_counter.sv
// Per-frame CI one/zero counter for NUM_CH channels with frame-size check and done pulse.
// Counter wrap behaviour is selected by the CI_CNT_SAT_EN macro inside ci_ch_counter.
module ci_multi_counter import ci_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int COLS   = 7,
  parameter int ROWS   = 7
) (
  input  logic clk,
  input  logic rst,
  ci_multi_counter_if.slave bus
);

  localparam int               PIX_W   = pix_cnt_width(COLS * ROWS);
  localparam logic [PIX_W-1:0] PIX_EXP = PIX_W'(COLS * ROWS);
  localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};

  state_e                    state_q, state_d;
  logic [PIX_W-1:0]          pix_q, pix_d;
  logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NUM_CH*CNT_W-1:0]   ones_q, ones_d, zeros_q, zeros_d;
  logic [NUM_CH-1:0]         ovf_q, ovf_d;
  logic                      start, count;
  logic [NUM_CH*CNT_W-1:0]   ones_nxt, zeros_nxt;
  logic [NUM_CH-1:0]         ovf_nxt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ci_ch_counter #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (start),
      .inc_i     (start | count),
      .bit_i     (bus.ci_i[k]),
      .ones_d_o  (ones_nxt[k*CNT_W +: CNT_W]),
      .zeros_d_o (zeros_nxt[k*CNT_W +: CNT_W]),
      .ovf_d_o   (ovf_nxt[k])
    );
  end

  // A sample in the DONE cycle starts a new frame; the latched results stay untouched.
  always_comb begin
    start   = 1'b0;
    count   = 1'b0;
    state_d = state_q;
    pix_d   = pix_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ones_d  = ones_q;
    zeros_d = zeros_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (bus.valid_i) begin
          count = 1'b1;
          if (pix_q != PIX_MAX) pix_d = pix_q + 1'b1;
        end
        if (bus.frame_done_i) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ones_d  = ones_nxt;
          zeros_d = zeros_nxt;
          ovf_d   = ovf_nxt;
          err_d   = (pix_d != PIX_EXP);
        end
      end
      default: begin
        if (bus.valid_i) begin
          start   = 1'b1;
          state_d = ACCUM;
          busy_d  = 1'b1;
          pix_d   = PIX_W'(1);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pix_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ones_q  <= '0;
      zeros_q <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ones_q  <= ones_d;
      zeros_q <= zeros_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.ones_o      = ones_q;
  assign bus.zeros_o     = zeros_q;
  assign bus.count_err_o = err_q;
  assign bus.ovf_o       = ovf_q;

endmodule

// File: tb/tb_ci_multi_counter.sv
// Directed bench for ci_multi_counter: a 16-bit instance for frame behaviour and a 4-bit one for overflow.
module tb_ci_multi_counter;
  import ci_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;

  ci_multi_counter_if #(.NUM_CH(3), .CNT_W(16)) bus ();
  ci_multi_counter_if #(.NUM_CH(3), .CNT_W(4))  sbus ();

  ci_multi_counter #(.NUM_CH(3), .CNT_W(16), .COLS(7), .ROWS(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ci_multi_counter #(.NUM_CH(3), .CNT_W(4), .COLS(7), .ROWS(7)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done_o === 1'b1) done_cnt++;

  task automatic drive(input logic v, input logic [2:0] ci, input logic fd);
    bus.valid_i      = v;
    bus.ci_i         = ci;
    bus.frame_done_i = fd;
    @(negedge clk);
  endtask

  task automatic frame(input int n, input logic [2:0] a, input logic [2:0] b);
    for (int i = 0; i < n; i++) drive(1'b1, (i % 2 == 0) ? a : b, (i == n - 1));
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b0, 3'b000, 1'b0);
    drive(1'b0, 3'b000, 1'b0);
    checks++;
    if ({bus.busy_o, bus.done_o, bus.count_err_o, bus.ovf_o} !== 6'b0 || bus.ones_o !== 48'd0 || bus.zeros_o !== 48'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got busy=%0b done=%0b err=%0b ovf=%b ones=%h zeros=%h want all 0",
               bus.busy_o, bus.done_o, bus.count_err_o, bus.ovf_o, bus.ones_o, bus.zeros_o);
    end
    rst = 1'b1;
    drive(1'b0, 3'b000, 1'b1);
    drive(1'b0, 3'b000, 1'b0);
    checks++;
    if (done_cnt !== 0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_frame_done got done_cnt=%0d busy=%0b want 0 0", done_cnt, bus.busy_o);
    end
  endtask

  task automatic test_basic;
    int d0;
    d0 = done_cnt;
    frame(49, 3'b101, 3'b101);
    checks++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done got done=%0b busy=%0b want 1 0", bus.done_o, bus.busy_o);
    end
    checks++;
    if (bus.ones_o !== {16'd49, 16'd0, 16'd49} || bus.zeros_o !== {16'd0, 16'd49, 16'd0}) begin
      errors++;
      $display("[TB] FAIL basic_counts got ones=%h zeros=%h want 003100000031 000000310000", bus.ones_o, bus.zeros_o);
    end
    checks++;
    if (bus.count_err_o !== 1'b0 || bus.ovf_o !== 3'b000) begin
      errors++;
      $display("[TB] FAIL basic_flags got err=%0b ovf=%b want 0 000", bus.count_err_o, bus.ovf_o);
    end
    drive(1'b0, 3'b000, 1'b0);
    checks++;
    if (bus.done_o !== 1'b0 || done_cnt !== d0 + 1) begin
      errors++;
      $display("[TB] FAIL basic_pulse got done=%0b pulses=%0d want 0 %0d", bus.done_o, done_cnt - d0, 1);
    end
  endtask

  task automatic test_alternate;
    frame(49, 3'b111, 3'b000);
    checks++;
    if (bus.ones_o !== {3{16'd25}} || bus.zeros_o !== {3{16'd24}} || bus.count_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alternate got ones=%h zeros=%h err=%0b want 25/24 per channel err 0",
               bus.ones_o, bus.zeros_o, bus.count_err_o);
    end
    drive(1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_count_err;
    frame(40, 3'b011, 3'b011);
    checks++;
    if (bus.count_err_o !== 1'b1 || bus.ones_o !== {16'd0, 16'd40, 16'd40} || bus.zeros_o !== {16'd40, 16'd0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL short_frame got err=%0b ones=%h zeros=%h want 1 000000280028 002800000000",
               bus.count_err_o, bus.ones_o, bus.zeros_o);
    end
    drive(1'b0, 3'b000, 1'b0);
    frame(49, 3'b101, 3'b101);
    checks++;
    if (bus.count_err_o !== 1'b0 || bus.done_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_clear got err=%0b done=%0b want 0 1", bus.count_err_o, bus.done_o);
    end
    drive(1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_back_to_back;
    frame(49, 3'b001, 3'b001);
    checks++;
    if (bus.done_o !== 1'b1 || bus.ones_o !== {16'd0, 16'd0, 16'd49}) begin
      errors++;
      $display("[TB] FAIL b2b_first got done=%0b ones=%h want 1 000000000031", bus.done_o, bus.ones_o);
    end
    for (int i = 0; i < 10; i++) drive(1'b1, 3'b110, 1'b0);
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.ones_o !== {16'd0, 16'd0, 16'd49} || bus.zeros_o !== {16'd49, 16'd49, 16'd0}) begin
      errors++;
      $display("[TB] FAIL b2b_hold got done=%0b busy=%0b ones=%h zeros=%h want 0 1 000000000031 003100310000",
               bus.done_o, bus.busy_o, bus.ones_o, bus.zeros_o);
    end
    frame(39, 3'b110, 3'b110);
    checks++;
    if (bus.done_o !== 1'b1 || bus.ones_o !== {16'd49, 16'd49, 16'd0} || bus.zeros_o !== {16'd0, 16'd0, 16'd49} || bus.count_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second got done=%0b ones=%h zeros=%h err=%0b want 1 003100310000 000000000031 0",
               bus.done_o, bus.ones_o, bus.zeros_o, bus.count_err_o);
    end
    drive(1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_overflow;
    logic [3:0] exp_cnt;
`ifdef CI_CNT_SAT_EN
    exp_cnt = 4'd15;
`else
    exp_cnt = 4'd4;
`endif
    for (int i = 0; i < 20; i++) begin
      sbus.valid_i      = 1'b1;
      sbus.ci_i         = 3'b001;
      sbus.frame_done_i = (i == 19);
      @(negedge clk);
    end
    sbus.valid_i      = 1'b0;
    sbus.frame_done_i = 1'b0;
    checks++;
    if (sbus.done_o !== 1'b1 || sbus.ones_o[3:0] !== exp_cnt || sbus.zeros_o[7:4] !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL ovf_counts got done=%0b ones0=%0d zeros1=%0d want 1 %0d %0d",
               sbus.done_o, sbus.ones_o[3:0], sbus.zeros_o[7:4], exp_cnt, exp_cnt);
    end
    checks++;
    if (sbus.ovf_o !== 3'b111 || sbus.count_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_flags got ovf=%b err=%0b want 111 1", sbus.ovf_o, sbus.count_err_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 30; i++) drive(1'b1, 3'b101, 1'b0);
    rst = 1'b0;
    drive(1'b0, 3'b000, 1'b0);
    checks++;
    if ({bus.busy_o, bus.done_o, bus.count_err_o, bus.ovf_o} !== 6'b0 || bus.ones_o !== 48'd0 || bus.zeros_o !== 48'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset got busy=%0b done=%0b err=%0b ovf=%b ones=%h zeros=%h want all 0",
               bus.busy_o, bus.done_o, bus.count_err_o, bus.ovf_o, bus.ones_o, bus.zeros_o);
    end
    rst = 1'b1;
    drive(1'b0, 3'b000, 1'b0);
    drive(1'b0, 3'b000, 1'b0);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("[TB] FAIL mid_reset_nodone got pulses=%0d want 0", done_cnt - d0);
    end
    frame(49, 3'b010, 3'b010);
    checks++;
    if (bus.ones_o !== {16'd0, 16'd49, 16'd0} || bus.zeros_o !== {16'd49, 16'd0, 16'd49} || bus.count_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset got ones=%h zeros=%h err=%0b want 000000310000 003100000031 0",
               bus.ones_o, bus.zeros_o, bus.count_err_o);
    end
    drive(1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    done_cnt          = 0;
    rst               = 1'b0;
    bus.valid_i       = 1'b0;
    bus.ci_i          = 3'b000;
    bus.frame_done_i  = 1'b0;
    sbus.valid_i      = 1'b0;
    sbus.ci_i         = 3'b000;
    sbus.frame_done_i = 1'b0;
    test_reset;
    test_basic;
    test_alternate;
    test_count_err;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
